// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared widths and writeback request type for the register-file write arbiter
package reg_wb_arbiter_pkg;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;
  localparam logic [AWIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// rtl/reg_wb_arbiter_wb_fifo.sv - B-side writeback queue; every slot is exposed so pending values can be bypassed
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  wb_req_t               push_req,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   entry_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t [DEPTH-1:0] mem;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] off;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr[PW-1:0]];
  assign entries = mem;

  // A slot is live when its distance from the read pointer is below the fill count
  always_comb begin
    off = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr[PW-1:0];
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[PW-1:0]] <= push_req;
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - shares the reg_file write port between the ALU path (A) and a queued load unit (B)
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_data,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic              byp1_hit,
  output logic [DWIDTH-1:0] byp1_data,
  output logic              byp2_hit,
  output logic [DWIDTH-1:0] byp2_data
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t             fifo_head;
  wb_req_t [DEPTH-1:0] fifo_entries;
  logic    [DEPTH-1:0] fifo_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                force_pop;
  logic                a_take;
  logic [SW-1:0]       starve;

  assign force_pop = (starve == SW'(STARVE_LIMIT));
  assign b_ready   = !rst && !fifo_full;
  assign push      = b_valid && b_ready;
  assign a_ready   = !rst && !(!fifo_empty && force_pop);
  assign pop       = !rst && !fifo_empty && (!a_valid || force_pop);
  assign a_take    = a_valid && a_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_req    ({b_addr, b_data}),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entries     (fifo_entries),
    .entry_valid (fifo_valid)
  );

  // Writes to x0 still load wa/wd but never raise the enable
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (pop) begin
      rf_we <= (fifo_head.addr != REG_ZERO);
      rf_wa <= fifo_head.addr;
      rf_wd <= fifo_head.data;
    end else if (a_take) begin
      rf_we <= (a_addr != REG_ZERO);
      rf_wa <= a_addr;
      rf_wd <= a_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || pop) starve <= '0;
    else if (!force_pop)          starve <= starve + SW'(1);
  end

  // At most one in-flight write per register, so OR-merging matches is exact
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && fifo_entries[i].addr == ra1) begin
        byp1_hit  = 1'b1;
        byp1_data = byp1_data | fifo_entries[i].data;
      end
      if (fifo_valid[i] && fifo_entries[i].addr == ra2) begin
        byp2_hit  = 1'b1;
        byp2_data = byp2_data | fifo_entries[i].data;
      end
    end
    if (rf_we && rf_wa == ra1) begin
      byp1_hit  = 1'b1;
      byp1_data = byp1_data | rf_wd;
    end
    if (rf_we && rf_wa == ra2) begin
      byp2_hit  = 1'b1;
      byp2_data = byp2_data | rf_wd;
    end
    if (ra1 == REG_ZERO) begin
      byp1_hit  = 1'b0;
      byp1_data = '0;
    end
    if (ra2 == REG_ZERO) begin
      byp2_hit  = 1'b0;
      byp2_data = '0;
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - queue-based reference model with directed scenarios and randomized traffic
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NREG  = 1 << AWIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [AWIDTH-1:0] a_addr, b_addr, ra1, ra2, rf_wa;
  logic [DWIDTH-1:0] a_data, b_data, rf_wd, byp1_data, byp2_data;
  logic              rf_we, byp1_hit, byp2_hit;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data)
  );

  int passed = 0;
  int total  = 0;

  // Reference state: pending B writes in order, A-win count, and the write-port register
  wb_req_t           q[$];
  int                losses;
  logic              m_we;
  logic [AWIDTH-1:0] m_wa;
  logic [DWIDTH-1:0] m_wd;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DWIDTH:0] m_lookup(logic [AWIDTH-1:0] ra);
    logic [DWIDTH:0] r;
    r = '0;
    if (ra != 0) begin
      foreach (q[i]) if (q[i].addr == ra) r = {1'b1, q[i].data};
      if (m_we && m_wa == ra) r = {1'b1, m_wd};
    end
    return r;
  endfunction

  task automatic compare();
    logic [DWIDTH:0] e1, e2;
    chk("rf_we", rf_we, m_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    if (rst) begin
      chk("a_ready_in_reset", a_ready, 0);
      chk("b_ready_in_reset", b_ready, 0);
    end else begin
      chk("b_ready", b_ready, q.size() < DEPTH);
      if (a_valid) chk("a_ready", a_ready, !(q.size() > 0 && losses == LIMIT));
    end
    e1 = m_lookup(ra1);
    e2 = m_lookup(ra2);
    chk("byp1_hit", byp1_hit, e1[DWIDTH]);
    chk("byp1_data", byp1_data, e1[DWIDTH-1:0]);
    chk("byp2_hit", byp2_hit, e2[DWIDTH]);
    chk("byp2_data", byp2_data, e2[DWIDTH-1:0]);
  endtask

  task automatic advance();
    wb_req_t h;
    bit nonempty, frc, do_pop, a_acc, do_push;
    if (rst) begin
      q.delete();
      losses = 0;
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
    end else begin
      nonempty = q.size() > 0;
      frc      = losses == LIMIT;
      do_pop   = nonempty && (!a_valid || frc);
      a_acc    = a_valid && !(nonempty && frc);
      do_push  = b_valid && q.size() < DEPTH;
      if (do_pop) begin
        h = q.pop_front();
        m_we = h.addr != 0;
        m_wa = h.addr;
        m_wd = h.data;
      end else if (a_acc) begin
        m_we = a_addr != 0;
        m_wa = a_addr;
        m_wd = a_data;
      end else begin
        m_we = 1'b0;
      end
      if (!nonempty || do_pop) losses = 0;
      else if (losses < LIMIT) losses++;
      if (do_push) q.push_back('{addr: b_addr, data: b_data});
    end
  endtask

  task automatic apply(input bit r, input bit av, input logic [AWIDTH-1:0] aa, input logic [DWIDTH-1:0] ad,
                       input bit bv, input logic [AWIDTH-1:0] ba, input logic [DWIDTH-1:0] bd,
                       input logic [AWIDTH-1:0] r1, input logic [AWIDTH-1:0] r2);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; ra1 = r1; ra2 = r2;
    #1;
    compare();
  endtask

  task automatic tick();
    advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AWIDTH-1:0] pick(logic [NREG-1:0] busy);
    logic [AWIDTH-1:0] a;
    for (int t = 0; t < 64; t++) begin
      a = AWIDTH'($urandom_range(0, NREG - 1));
      if (!busy[a]) return a;
    end
    return '0;
  endfunction

  initial begin
    logic [NREG-1:0]   busy;
    logic [AWIDTH-1:0] aa, ba, r1, r2;
    rst = 1'b1; a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0; ra1 = '0; ra2 = '0;
    losses = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    @(posedge clk);
    #1;

    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_wa", rf_wa, 0);
    chk("reset_rf_wd", rf_wd, 0);
    apply(1, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 0, 0);
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);
    tick();

    apply(0, 1, 5'd3, 32'h11, 0, 0, 0, 5'd3, 0);
    chk("a_only_ready", a_ready, 1);
    tick();
    chk("a_only_we", rf_we, 1);
    chk("a_only_wa", rf_wa, 3);
    chk("a_only_wd", rf_wd, 32'h11);

    apply(0, 0, 0, 0, 1, 5'd5, 32'h22, 5'd5, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("b_queued_hit", byp1_hit, 1);
    chk("b_queued_data", byp1_data, 32'h22);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("b_out_we", rf_we, 1);
    chk("b_out_wa", rf_wa, 5);
    chk("b_out_wd", rf_wd, 32'h22);
    chk("b_out_hit", byp1_hit, 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("b_committed_miss", byp1_hit, 0);
    tick();

    for (int k = 0; k < 6; k++) begin
      apply(0, 1, AWIDTH'(8 + k), 32'h100 + k, k == 0, 5'd7, 32'h77, 5'd7, 0);
      if (k >= 1 && k <= 4) chk("starve_a_wins", a_ready, 1);
      if (k == 5) chk("starve_forced", a_ready, 0);
      tick();
    end
    chk("starve_pop_we", rf_we, 1);
    chk("starve_pop_wa", rf_wa, 7);
    chk("starve_pop_wd", rf_wd, 32'h77);

    for (int k = 0; k < 3; k++) begin
      apply(0, 1, AWIDTH'(16 + k), 32'h180 + k, 1, AWIDTH'(20 + k), 32'h200 + k, 5'd20, 5'd21);
      chk("full_b_ready", b_ready, k < 2);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      apply(0, 1, AWIDTH'(24 + k), 32'h300 + k, 0, 0, 0, 5'd20, 5'd21);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    apply(0, 1, 5'd0, 32'h1, 0, 0, 0, 0, 0);
    chk("x0_a_ready", a_ready, 1);
    tick();
    chk("x0_no_we", rf_we, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_no_hit", byp1_hit, 0);
    tick();

    for (int k = 0; k < 2; k++) begin
      apply(0, 1, AWIDTH'(1 + k), 32'h400 + k, 1, AWIDTH'(14 + k), 32'h500 + k, 5'd14, 5'd15);
      tick();
    end
    apply(1, 0, 0, 0, 0, 0, 0, 5'd14, 5'd15);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 5'd14, 5'd15);
    chk("rst_q_we", rf_we, 0);
    chk("rst_q_hit1", byp1_hit, 0);
    chk("rst_q_hit2", byp2_hit, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 5'd14, 5'd15);
      chk("rst_no_stale", rf_we, 0);
      tick();
    end

    for (int c = 0; c < 800; c++) begin
      busy = '0;
      foreach (q[i]) busy[q[i].addr] = 1'b1;
      if (m_we) busy[m_wa] = 1'b1;
      busy[0] = 1'b0;
      aa = pick(busy);
      busy[aa] = 1'b1;
      busy[0] = 1'b0;
      ba = pick(busy);
      r1 = AWIDTH'($urandom_range(0, NREG - 1));
      r2 = AWIDTH'($urandom_range(0, NREG - 1));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) r1 = q[$urandom_range(0, q.size() - 1)].addr;
      if (m_we && $urandom_range(0, 1) == 1) r2 = m_wa;
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, aa, $urandom,
            $urandom_range(0, 9) < 5, ba, $urandom, r1, r2);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
